// File: rtl/div_ctrl_pkg.sv
// Shared constants for the restoring-divider control FSM: one-hot state bit
// indices, state count and default operand width.
package div_ctrl_pkg;

    localparam int unsigned S_IDLE        = 0;
    localparam int unsigned S_INIT        = 1;
    localparam int unsigned S_SHIFT       = 2;
    localparam int unsigned S_SUB         = 3;
    localparam int unsigned S_CORR        = 4;
    localparam int unsigned S_OUT         = 5;
    localparam int unsigned N_STATES      = 6;
    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/dff.sv
// Team cell: W-bit D flip-flop, asynchronous active-low reset to all zeros.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/dff_rst_to_1.sv
// Team cell: W-bit D flip-flop, asynchronous active-low reset to all ones.
module dff_rst_to_1 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '1;
        else        q <= d;
    end

endmodule

// File: rtl/div_iter_counter.sv
// Iteration counter for the restoring divider; last flags the final iteration.
module div_iter_counter
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc)   cnt <= cnt + CNT_W'(1);
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/divider_ctrl.sv
// One-hot control FSM sequencing a restoring divider datapath
// (load, shift, subtract, restore/set, output) with done and divide-by-zero flags.
module divider_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic divisor_zero,
    input  logic rem_msb,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic busy,
    output logic done,
    output logic dbz
);

    logic [N_STATES-1:0] state_q;
    logic [N_STATES-1:0] state_d;
    logic [CNT_W-1:0]    cnt;
    logic                last;
    logic                dbz_d;

    logic st_idle, st_init, st_shift, st_sub, st_corr, st_out;

    assign st_idle  = state_q[S_IDLE];
    assign st_init  = state_q[S_INIT];
    assign st_shift = state_q[S_SHIFT];
    assign st_sub   = state_q[S_SUB];
    assign st_corr  = state_q[S_CORR];
    assign st_out   = state_q[S_OUT];

    // State register: IDLE bit resets to 1, every other bit to 0.
    for (genvar i = 0; i < int'(N_STATES); i++) begin : g_state
        if (i == int'(S_IDLE)) begin : g_idle
            dff_rst_to_1 #(.W(1)) u_ff (
                .clk   (clk),
                .reset (reset),
                .d     (state_d[i]),
                .q     (state_q[i])
            );
        end else begin : g_other
            dff #(.W(1)) u_ff (
                .clk   (clk),
                .reset (reset),
                .d     (state_d[i]),
                .q     (state_q[i])
            );
        end
    end

    // Next-state equations, one per one-hot bit.
    always_comb begin
        state_d          = '0;
        state_d[S_IDLE]  = (st_idle & ~start) | st_out;
        state_d[S_INIT]  = st_idle & start;
        state_d[S_SHIFT] = (st_init & ~divisor_zero) | (st_corr & ~last);
        state_d[S_SUB]   = st_shift;
        state_d[S_CORR]  = st_sub;
        state_d[S_OUT]   = (st_init & divisor_zero) | (st_corr & last);
    end

    // Counter holds at WIDTH-1 on the final exit so it never wraps mid-operation.
    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (st_init),
        .inc   (st_corr & ~last),
        .cnt   (cnt),
        .last  (last)
    );

    assign c0   = st_init;
    assign c1   = st_shift;
    assign c2   = st_sub;
    assign c3   = st_corr & rem_msb;
    assign c4   = st_corr & ~rem_msb;
    assign c5   = st_out;
    assign busy = ~st_idle;

    // dbz is rewritten only in INIT, so it holds through the done pulse and beyond.
    assign dbz_d = st_init ? divisor_zero : dbz;

    dff #(.W(1)) u_done (
        .clk   (clk),
        .reset (reset),
        .d     (st_out),
        .q     (done)
    );

    dff #(.W(1)) u_dbz (
        .clk   (clk),
        .reset (reset),
        .d     (dbz_d),
        .q     (dbz)
    );

    a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot(state_q));
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt <= CNT_W'(WIDTH - 1));

endmodule

// File: tb/tb_divider_ctrl.sv
// Scoreboard bench for divider_ctrl: a bench-side datapath follows the control
// pulses, and a monitor checks each done pulse against queued expectations.
module tb_divider_ctrl;
    import div_ctrl_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 3 * W + 3;

    typedef struct {
        int done_cyc;
        int c5_cyc;
        int dbz;
        int n_iter;
        int chk_qr;
        int q;
        int r;
    } item_t;

    logic clk, reset, start, divisor_zero, rem_msb;
    logic c0, c1, c2, c3, c4, c5, busy, done, dbz;

    item_t sb[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    op_s = 0;

    logic [W-1:0] dvd = '0, dvs = 8'd1;
    logic [W:0]   acc = '0, mreg = '0;
    logic [W-1:0] qreg = '0, q_out = '0, r_out = '0;

    int n0 = 0, n1 = 0, n2 = 0, n34 = 0, n5 = 0, c5_at = -1;

    divider_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .divisor_zero (divisor_zero),
        .rem_msb      (rem_msb),
        .c0           (c0),
        .c1           (c1),
        .c2           (c2),
        .c3           (c3),
        .c4           (c4),
        .c5           (c5),
        .busy         (busy),
        .done         (done),
        .dbz          (dbz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign divisor_zero = (dvs == '0);
    assign rem_msb      = acc[W];

    // Bench-side restoring datapath driven by the control pulses.
    always @(posedge clk) begin
        if (c0) begin
            acc  <= '0;
            qreg <= dvd;
            mreg <= {1'b0, dvs};
        end else if (c1) begin
            acc  <= {acc[W-1:0], qreg[W-1]};
            qreg <= {qreg[W-2:0], 1'b0};
        end else if (c2) begin
            acc <= acc - mreg;
        end else if (c3) begin
            acc     <= acc + mreg;
            qreg[0] <= 1'b0;
        end else if (c4) begin
            qreg[0] <= 1'b1;
        end else if (c5) begin
            q_out <= qreg;
            r_out <= acc[W-1:0];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outs_vec();
        return int'({busy, done, dbz, c0, c1, c2, c3, c4, c5});
    endfunction

    // Monitor: counts control pulses per operation and scores each done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            n0 = 0; n1 = 0; n2 = 0; n34 = 0; n5 = 0; c5_at = -1;
        end else begin
            check("state_onehot", int'($onehot(dut.state_q)), 1);
            check("ctrl_at_most_one", int'($onehot0({c0, c1, c2, c3, c4, c5})), 1);
            if (c0) n0++;
            if (c1) n1++;
            if (c2) n2++;
            if (c3 || c4) n34++;
            if (c5) begin n5++; c5_at = cyc; end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    item_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("c5_cycle", c5_at, e.c5_cyc);
                    check("dbz", int'(dbz), e.dbz);
                    check("busy_at_done", int'(busy), 0);
                    check("c0_count", n0, 1);
                    check("c1_count", n1, e.n_iter);
                    check("c2_count", n2, e.n_iter);
                    check("c3c4_count", n34, e.n_iter);
                    check("c5_count", n5, 1);
                    if (e.chk_qr != 0) begin
                        check("quotient", int'(q_out), e.q);
                        check("remainder", int'(r_out), e.r);
                    end
                end
                n0 = 0; n1 = 0; n2 = 0; n34 = 0; n5 = 0; c5_at = -1;
            end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
                check("done_missing", 0, 1);
                void'(sb.pop_front());
                n0 = 0; n1 = 0; n2 = 0; n34 = 0; n5 = 0; c5_at = -1;
            end
        end
    end

    // Raise start at a negedge; op_s is the cycle index it is sampled after.
    task automatic issue(input int a, input int b, input int q, input int r, input bit push);
        item_t e;
        @(negedge clk);
        dvd  = W'(a);
        dvs  = W'(b);
        op_s = cyc;
        if (push) begin
            e.done_cyc = (b == 0) ? op_s + 3 : op_s + LAT;
            e.c5_cyc   = e.done_cyc - 1;
            e.dbz      = (b == 0) ? 1 : 0;
            e.n_iter   = (b == 0) ? 0 : W;
            e.chk_qr   = (b == 0) ? 0 : 1;
            e.q        = q;
            e.r        = r;
            sb.push_back(e);
        end
        start = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset_outputs", outs_vec(), 0);
        check("in_reset_idle_bit", int'(dut.state_q[S_IDLE]), 1);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_outputs", outs_vec(), 0);
            check("idle_bit", int'(dut.state_q[S_IDLE]), 1);
        end

        issue(143, 11, 13, 0, 1);
        drain();

        issue(57, 0, 0, 0, 1);
        drain();
        repeat (5) @(negedge clk);
        check("dbz_held", int'(dbz), 1);

        // Stray start pulses while busy must be ignored.
        issue(200, 7, 28, 4, 1);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 20);
            if (k == 3) check("dbz_cleared", int'(dbz), 0);
        end
        drain();

        issue(5, 9, 0, 5, 1);
        drain();
        issue(255, 1, 255, 0, 1);
        drain();
        issue(255, 255, 1, 0, 1);
        drain();

        // Abort mid-operation; no done may follow.
        issue(143, 11, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("abort_outputs", outs_vec(), 0);
        check("abort_idle_bit", int'(dut.state_q[S_IDLE]), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        issue(77, 7, 11, 0, 1);
        drain();

        // start held high: the second start is taken in the done cycle.
        issue(100, 3, 33, 1, 1);
        begin
            item_t e2;
            e2.done_cyc = op_s + 2 * LAT;
            e2.c5_cyc   = e2.done_cyc - 1;
            e2.dbz      = 0;
            e2.n_iter   = W;
            e2.chk_qr   = 1;
            e2.q        = 33;
            e2.r        = 1;
            sb.push_back(e2);
        end
        for (int k = 1; k <= LAT + 1; k++) @(negedge clk);
        start = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
